// File: rtl/ps2_key_decoder_if.sv
// PS/2 line and key-output bundle for ps2_key_decoder.
// The master side drives the raw PS/2 lines and consumes the decoded key.
// The slave side is the decoder itself.
interface ps2_key_decoder_if;
    logic       ps2_clk;    // raw PS/2 clock, asynchronous to clk
    logic       ps2_data;   // raw PS/2 data, asynchronous to clk
    logic [7:0] key;        // code of the held key, 0x00 when none is held
    logic       key_valid;  // one-cycle pulse on every accepted mapped make
    logic       frame_err;  // one-cycle pulse on a framing (or parity) error

    modport master (output ps2_clk, ps2_data, input key, key_valid, frame_err);
    modport slave  (input ps2_clk, ps2_data, output key, key_valid, frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scancode receiver and key decoder.
// Synchronises and glitch-filters the PS/2 lines, receives 11-bit frames,
// tracks E0/F0 prefixes and holds the ASCII-style code of the last pressed
// key on `key` until that same key is released.
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad odd
// parity (with a frame_err pulse); otherwise the parity bit is ignored.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input logic              clk,
    input logic              rst,
    ps2_key_decoder_if.slave bus
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DECODE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_clk_s1, r_clk_s2;
    logic            r_dat_s1, r_dat_s2;
    logic [FW-1:0]   r_flt_cnt;
    logic            r_flt_clk;
    logic            r_flt_clk_d;
    logic            w_fall;

    logic [7:0]      r_shift;
    logic            r_parity;
    logic [2:0]      r_bit_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic            w_receiving;
    logic            w_tmo_hit;
    logic            w_par_ok;
    logic            w_frame_ok;

    logic            r_e0_seen;
    logic            r_f0_seen;
    logic [7:0]      w_code;
    logic [7:0]      r_key;
    logic            r_key_valid;
    logic            r_frame_err;

    // Two-stage synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN
    // consecutive samples that disagree with its current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flt_cnt   <= '0;
            r_flt_clk   <= 1'b1;
            r_flt_clk_d <= 1'b1;
        end else begin
            r_flt_clk_d <= r_flt_clk;
            if (r_clk_s2 != r_flt_clk) begin
                if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                    r_flt_clk <= r_clk_s2;
                    r_flt_cnt <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 1'b1;
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    assign w_fall      = r_flt_clk_d & ~r_flt_clk;
    assign w_receiving = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_tmo_hit   = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_shift, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_frame_ok = r_dat_s2 & w_par_ok;

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Receive FSM next-state logic; one step per fall event, DECODE is a
    // single free-running cycle, and a silent line aborts a partial frame.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch
        // is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !r_dat_s2) w_state_next = S_DATA;
            S_DATA:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_next = S_PARITY;
            S_PARITY: if (w_fall) w_state_next = S_STOP;
            S_STOP:   if (w_fall) w_state_next = w_frame_ok ? S_DECODE : S_IDLE;
            S_DECODE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (w_receiving && !w_fall && w_tmo_hit) w_state_next = S_IDLE;
    end

    // Set-2 to key-code map; 0x00 means the scancode is not mapped.
    always_comb begin
        w_code = 8'h00;
        case ({r_e0_seen, r_shift})
            9'h016: w_code = 8'h31;
            9'h01E: w_code = 8'h32;
            9'h026: w_code = 8'h33;
            9'h076: w_code = 8'h1b;
            9'h05A: w_code = 8'h0d;
            9'h029: w_code = 8'h20;
            9'h01D: w_code = 8'h77;
            9'h01C: w_code = 8'h61;
            9'h01B: w_code = 8'h73;
            9'h023: w_code = 8'h64;
            9'h175: w_code = 8'h80;
            9'h172: w_code = 8'h81;
            9'h16B: w_code = 8'h82;
            9'h174: w_code = 8'h83;
            9'h15A: w_code = 8'h0d;
            default: w_code = 8'h00;
        endcase
    end

    // Frame datapath: shift register, bit/timeout counters and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_bit_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= (r_state == S_STOP) && w_fall && !w_frame_ok;
            if (w_receiving && !w_fall) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                        r_tmo_cnt <= '0;
            if (w_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_parity <= r_dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    // Decode a received byte: prefixes update flags, makes load the key,
    // and a break clears the key only if it releases the last-pressed key.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0_seen   <= 1'b0;
            r_f0_seen   <= 1'b0;
            r_key       <= 8'h00;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_state == S_DECODE) begin
                if (r_shift == 8'hE0) begin
                    r_e0_seen <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_f0_seen <= 1'b1;
                end else begin
                    r_e0_seen <= 1'b0;
                    r_f0_seen <= 1'b0;
                    if (!r_f0_seen) begin
                        if (w_code != 8'h00) begin
                            r_key       <= w_code;
                            r_key_valid <= 1'b1;
                        end
                    end else if ((w_code != 8'h00) && (w_code == r_key)) begin
                        r_key <= 8'h00;
                    end
                end
            end
        end
    end

    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: drives PS/2 frames bit by bit,
// queues the expected key/pulse outcome of each frame and compares it once
// the frame has been processed.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TMO        = 1000;
    localparam int HALF       = 20;

    typedef struct {
        string      tag;
        logic [7:0] key;
        int         valids;
        int         errs;
    } exp_t;

    logic   clk;
    logic   rst;
    int     n_total;
    int     n_bad;
    int     mon_v;
    int     mon_e;
    int     base_v;
    int     base_e;
    exp_t   sb[$];

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts cycles with key_valid / frame_err high.
    initial begin
        mon_v = 0;
        mon_e = 0;
        forever begin
            @(negedge clk);
            if (!rst && bus.key_valid) mon_v++;
            if (!rst && bus.frame_err) mon_e++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive n bits of a frame, LSB first; data changes while clk is high.
    // With chk_lat set, measure the key_valid latency after the last fall.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit chk_lat);
        int lat;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (chk_lat && (i == n - 1)) begin
                lat = 0;
                for (int c = 1; c <= 40; c++) begin
                    @(negedge clk);
                    if (bus.key_valid) begin
                        lat = c;
                        break;
                    end
                end
                check("latency", lat, 2 + FILTER_LEN + 2);
                @(negedge clk);
                check("valid_width", {31'd0, bus.key_valid}, 32'd0);
                repeat (HALF) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bus.ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    // Send one byte as a full frame and score its outcome.
    task automatic send_byte(input string tag, input logic [7:0] b,
                             input logic [7:0] exp_key, input int exp_v, input int exp_e,
                             input bit bad_par, input bit bad_stop, input bit chk_lat);
        logic       par;
        logic [10:0] bits;
        exp_t        e;
        exp_t        got;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        base_v = mon_v;
        base_e = mon_e;
        e.tag = tag; e.key = exp_key; e.valids = exp_v; e.errs = exp_e;
        sb.push_back(e);
        send_bits(bits, 11, chk_lat);
        repeat (5) @(negedge clk);
        got = sb.pop_front();
        check({got.tag, "_key"}, {24'd0, bus.key}, {24'd0, got.key});
        check({got.tag, "_valid"}, mon_v - base_v, got.valids);
        check({got.tag, "_err"}, mon_e - base_e, got.errs);
    endtask

    // Watchdog: the run must always terminate.
    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_key", {24'd0, bus.key}, 32'h00);
        check("rst_valid", {31'd0, bus.key_valid}, 32'd0);
        check("rst_err", {31'd0, bus.frame_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic make with latency measurement.
        send_byte("mk16", 8'h16, 8'h31, 1, 0, 0, 0, 1);

        // ESC make/break.
        send_byte("mk76", 8'h76, 8'h1b, 1, 0, 0, 0, 0);
        send_byte("f0a",  8'hF0, 8'h1b, 0, 0, 0, 0, 0);
        send_byte("brk76", 8'h76, 8'h00, 0, 0, 0, 0, 0);

        // Extended arrow make/break; final bare 75 proves e0 was cleared.
        send_byte("e0a",  8'hE0, 8'h00, 0, 0, 0, 0, 0);
        send_byte("mkup", 8'h75, 8'h80, 1, 0, 0, 0, 0);
        send_byte("e0b",  8'hE0, 8'h80, 0, 0, 0, 0, 0);
        send_byte("f0b",  8'hF0, 8'h80, 0, 0, 0, 0, 0);
        send_byte("brkup", 8'h75, 8'h00, 0, 0, 0, 0, 0);
        send_byte("bare75", 8'h75, 8'h00, 0, 0, 0, 0, 0);

        // Overlap: last pressed wins, release of the earlier key ignored.
        send_byte("mk5a", 8'h5A, 8'h0d, 1, 0, 0, 0, 0);
        send_byte("mk29", 8'h29, 8'h20, 1, 0, 0, 0, 0);
        send_byte("f0c",  8'hF0, 8'h20, 0, 0, 0, 0, 0);
        send_byte("brk5a", 8'h5A, 8'h20, 0, 0, 0, 0, 0);
        send_byte("f0d",  8'hF0, 8'h20, 0, 0, 0, 0, 0);
        send_byte("brk29", 8'h29, 8'h00, 0, 0, 0, 0, 0);

        // Bad parity frame.
`ifdef PS2_PARITY_CHECK_EN
        send_byte("badpar", 8'h16, 8'h00, 0, 1, 1, 0, 0);
`else
        send_byte("badpar", 8'h16, 8'h31, 1, 0, 1, 0, 0);
`endif
        send_byte("f0e",  8'hF0, bus.key, 0, 0, 0, 0, 0);
        send_byte("brk16", 8'h16, 8'h00, 0, 0, 0, 0, 0);

        // Bad stop bit leaves the E0 prefix intact.
        send_byte("e0c",  8'hE0, 8'h00, 0, 0, 0, 0, 0);
        send_byte("badstop", 8'h41, 8'h00, 0, 1, 0, 1, 0);
        send_byte("mkup2", 8'h75, 8'h80, 1, 0, 0, 0, 0);
        send_byte("e0d",  8'hE0, 8'h80, 0, 0, 0, 0, 0);
        send_byte("f0f",  8'hF0, 8'h80, 0, 0, 0, 0, 0);
        send_byte("brkup2", 8'h75, 8'h00, 0, 0, 0, 0, 0);

        // Partial frame (start + 4 data bits) abandoned by timeout.
        base_e = mon_e;
        send_bits({2'b11, 8'h26, 1'b0}, 5, 0);
        repeat (TMO + 10) @(negedge clk);
        check("tmo_err", mon_e - base_e, 0);
        send_byte("mk26", 8'h26, 8'h33, 1, 0, 0, 0, 0);

        // Three-cycle glitch on ps2_clk with data low must not start a frame.
        @(negedge clk);
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        repeat (30) @(negedge clk);
        bus.ps2_data = 1'b1;
        send_byte("mk1c", 8'h1C, 8'h61, 1, 0, 0, 0, 0);

        // Reset in the middle of a frame.
        send_bits({2'b11, 8'h1E, 1'b0}, 5, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_key", {24'd0, bus.key}, 32'h00);
        check("midrst_valid", {31'd0, bus.key_valid}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_byte("mk1e", 8'h1E, 8'h32, 1, 0, 0, 0, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
